// File: rtl/puf_pkg.sv
// puf_pkg -- shared constants and helpers for the PUF response buffer.
//   WPE       : words per buffered entry (stat + eight auth words)
//   STAT_IDX  : word index of the status word
//   AUTH_BASE : word index of the first (most significant) auth word
//   ENTRY_W   : bits per entry, {stat, auth}
package puf_pkg;

  localparam int WORD_W    = 16;
  localparam int WPE       = 9;
  localparam int STAT_IDX  = 0;
  localparam int AUTH_BASE = 1;
  localparam int ENTRY_W   = 144;
  localparam int WSEL_W    = 4;

  localparam logic [WSEL_W-1:0] LAST_WSEL = 4'(WPE - 1);

  // Word idx of a packed {stat, auth} entry; word 0 is the top 16 bits.
  function automatic logic [WORD_W-1:0] entry_word(input logic [ENTRY_W-1:0] entry,
                                                   input int idx);
    return entry[ENTRY_W-1-idx*WORD_W -: WORD_W];
  endfunction

endpackage

// File: rtl/puf_resp_ptr.sv
// puf_resp_ptr -- head/tail/count/word-select/flag bookkeeping for the
// response buffer.
//   clk, rst      : clock, asynchronous active-high reset
//   i_save        : capture request
//   i_rd          : pop one word from the head entry
//   i_clr         : synchronous flush (wins over save/rd)
//   i_done        : run-complete level, folded into a sticky flag
//   o_wr_en       : capture accepted this cycle, write entry at o_tail
//   o_head/o_tail : entry pointers
//   o_cnt, o_wsel : complete entries held, word index inside head entry
//   o_ovf, o_done : sticky flags
module puf_resp_ptr
  import puf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_save,
  input  logic              i_rd,
  input  logic              i_clr,
  input  logic              i_done,
  output logic              o_wr_en,
  output logic [AW-1:0]     o_head,
  output logic [AW-1:0]     o_tail,
  output logic [CW-1:0]     o_cnt,
  output logic [WSEL_W-1:0] o_wsel,
  output logic              o_ovf,
  output logic              o_done
);

  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WSEL_W-1:0] wsel_q, wsel_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic empty, full, rd_ok, pop, push, drop;

  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == CW'(DEPTH));
    rd_ok = i_rd && !empty;
    pop   = rd_ok && (wsel_q == LAST_WSEL);
    // A final-word pop frees the head slot in the same cycle, so a full
    // buffer can still take the capture.
    push  = i_save && (!full || pop);
    drop  = i_save && !push;

    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    wsel_d = wsel_q;
    ovf_d  = ovf_q;
    done_d = done_q;

    if (i_clr) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      wsel_d = '0;
      ovf_d  = 1'b0;
      done_d = 1'b0;
    end else begin
      if (rd_ok) wsel_d = pop ? '0 : wsel_q + 1'b1;
      if (pop)   head_d = head_q + 1'b1;
      if (push)  tail_d = tail_q + 1'b1;
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      ovf_d  = ovf_q | drop;
      done_d = done_q | i_done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      wsel_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      wsel_q <= wsel_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign o_wr_en = push && !i_clr;
  assign o_head  = head_q;
  assign o_tail  = tail_q;
  assign o_cnt   = cnt_q;
  assign o_wsel  = wsel_q;
  assign o_ovf   = ovf_q;
  assign o_done  = done_q;

endmodule

// File: rtl/puf_resp_buf.sv
// puf_resp_buf -- DEPTH-entry FIFO of PUF responses, each read out as nine
// 16-bit words (stat first, then auth from the most significant word).
//   clk, rst        : clock, asynchronous active-high reset
//   i_save          : capture strobe; i_auth/i_stat valid with it
//   i_done          : run-complete level (sticky in o_done)
//   i_rd            : pop one word from the head entry
//   i_clr           : flush, clears flags
//   o_rd_data       : current head word (combinational, 0 when empty)
//   o_rd_vld        : buffer not empty
//   o_cnt           : complete entries held
//   o_wsel          : word index within head entry
//   o_ovf, o_done   : sticky overflow / run-complete flags
module puf_resp_buf #(
  parameter int DEPTH = 4,
  parameter int WPE   = puf_pkg::WPE,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_save,
  input  logic [127:0]  i_auth,
  input  logic [15:0]   i_stat,
  input  logic          i_done,
  input  logic          i_rd,
  input  logic          i_clr,
  output logic [15:0]   o_rd_data,
  output logic          o_rd_vld,
  output logic [CW-1:0] o_cnt,
  output logic [3:0]    o_wsel,
  output logic          o_ovf,
  output logic          o_done
);

  localparam int EW = puf_pkg::ENTRY_W;

  logic          wr_en;
  logic [AW-1:0] head, tail;

  puf_resp_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .i_save  (i_save),
    .i_rd    (i_rd),
    .i_clr   (i_clr),
    .i_done  (i_done),
    .o_wr_en (wr_en),
    .o_head  (head),
    .o_tail  (tail),
    .o_cnt   (o_cnt),
    .o_wsel  (o_wsel),
    .o_ovf   (o_ovf),
    .o_done  (o_done)
  );

  // Entry storage is deliberately not reset; o_rd_vld masks stale data.
  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail] <= {i_stat, i_auth};
  end

  // Word mux padded to 16 slots so any 4-bit o_wsel indexes in range.
  logic [EW-1:0] head_entry;
  logic [15:0]   head_words [16];

  assign head_entry = mem_q[head];

  for (genvar gi = 0; gi < 16; gi++) begin : g_word
    if (gi < WPE) begin : g_live
      assign head_words[gi] = puf_pkg::entry_word(head_entry, gi);
    end else begin : g_pad
      assign head_words[gi] = '0;
    end
  end

  assign o_rd_vld  = (o_cnt != '0);
  assign o_rd_data = o_rd_vld ? head_words[o_wsel] : 16'h0000;

endmodule

// File: tb/tb_puf_resp_buf.sv
module tb_puf_resp_buf;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_save, i_done, i_rd, i_clr;
  logic [127:0]  i_auth;
  logic [15:0]   i_stat;
  logic [15:0]   o_rd_data;
  logic          o_rd_vld, o_ovf, o_done;
  logic [CW-1:0] o_cnt;
  logic [3:0]    o_wsel;

  puf_resp_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_save(i_save), .i_auth(i_auth), .i_stat(i_stat),
    .i_done(i_done), .i_rd(i_rd), .i_clr(i_clr), .o_rd_data(o_rd_data),
    .o_rd_vld(o_rd_vld), .o_cnt(o_cnt), .o_wsel(o_wsel), .o_ovf(o_ovf),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: queue of words still to be read, plus counters/flags.
  logic [15:0] exp_q[$];
  int          m_cnt, m_wsel;
  logic        m_ovf, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0; m_wsel = 0; m_ovf = 1'b0; m_done = 1'b0;
  endtask

  task automatic check_outputs();
    check("rd_vld", 32'(o_rd_vld), 32'(m_cnt != 0));
    check("rd_data", 32'(o_rd_data), (m_cnt != 0) ? 32'(exp_q[0]) : 32'h0);
    check("cnt", 32'(o_cnt), 32'(m_cnt));
    check("wsel", 32'(o_wsel), 32'(m_wsel));
    check("ovf", 32'(o_ovf), 32'(m_ovf));
    check("done", 32'(o_done), 32'(m_done));
  endtask

  // One clock: drive, check current outputs, advance the model, clock.
  task automatic cyc(input logic sv, input logic [15:0] st, input logic [127:0] au,
                     input logic rd, input logic cl, input logic dn);
    logic vld, rd_ok, last, push, drop;
    @(negedge clk);
    i_save = sv; i_stat = st; i_auth = au; i_rd = rd; i_clr = cl; i_done = dn;
    #1;
    check_outputs();
    vld   = (m_cnt != 0);
    rd_ok = rd && vld;
    last  = rd_ok && (m_wsel == 8);
    push  = sv && ((m_cnt < DEPTH) || last);
    drop  = sv && !push;
    if (cl) begin
      model_reset();
    end else begin
      if (rd_ok) begin
        void'(exp_q.pop_front());
        m_wsel = last ? 0 : m_wsel + 1;
      end
      if (push) begin
        exp_q.push_back(st);
        for (int k = 0; k < 8; k++) exp_q.push_back(au[127-16*k -: 16]);
      end
      m_cnt  = m_cnt + int'(push) - int'(last);
      m_ovf  = m_ovf | drop;
      m_done = m_done | dn;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic save(input logic [15:0] st, input logic [127:0] au);
    cyc(1'b1, st, au, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 16'h0, 128'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 16'h0, 128'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk);
    i_save = 1'b0; i_rd = 1'b0; i_clr = 1'b0; i_done = 1'b0;
    #1;
  endtask

  logic [127:0] auth_a;
  logic [15:0]  words_a [9];

  initial begin
    auth_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    words_a = '{16'hA5A5, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF,
                16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    rst = 1'b1;
    i_save = 1'b0; i_rd = 1'b0; i_clr = 1'b0; i_done = 1'b0;
    i_stat = '0; i_auth = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Single entry readout with explicit word values.
    save(16'hA5A5, auth_a);
    for (int w = 0; w < 9; w++) begin
      settle();
      check("single_word", 32'(o_rd_data), 32'(words_a[w]));
      rd();
    end
    settle();
    check("single_vld_end", 32'(o_rd_vld), 32'h0);

    // Overflow: fifth capture dropped.
    for (int s = 1; s <= 5; s++) save(16'(s), {8{16'(s * 3)}});
    settle();
    check("ovf_cnt", 32'(o_cnt), 32'd4);
    check("ovf_flag", 32'(o_ovf), 32'h1);
    for (int s = 1; s <= 4; s++) begin
      settle();
      check("ovf_stat", 32'(o_rd_data), 32'(s));
      for (int w = 0; w < 9; w++) rd();
    end
    clr();

    // Full with simultaneous final-word pop and capture.
    for (int s = 1; s <= 4; s++) save(16'(s), {8{16'(s + 16'h100)}});
    for (int w = 0; w < 8; w++) rd();
    cyc(1'b1, 16'h0009, {8{16'h0909}}, 1'b1, 1'b0, 1'b0);
    settle();
    check("fullpop_cnt", 32'(o_cnt), 32'd4);
    check("fullpop_ovf", 32'(o_ovf), 32'h0);
    for (int w = 0; w < 27; w++) rd();
    settle();
    check("fullpop_last_stat", 32'(o_rd_data), 32'h0009);
    for (int w = 0; w < 9; w++) rd();

    // Flush beats save and read.
    save(16'h1111, {8{16'h1111}});
    save(16'h2222, {8{16'h2222}});
    cyc(1'b1, 16'h3333, {8{16'h3333}}, 1'b1, 1'b1, 1'b0);
    settle();
    check("clr_cnt", 32'(o_cnt), 32'h0);
    check("clr_data", 32'(o_rd_data), 32'h0);

    // Reset mid-read.
    save(16'hBEEF, auth_a);
    for (int w = 0; w < 5; w++) rd();
    settle();
    check("pre_rst_wsel", 32'(o_wsel), 32'd5);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_cnt", 32'(o_cnt), 32'h0);
    check("rst_wsel", 32'(o_wsel), 32'h0);
    check("rst_data", 32'(o_rd_data), 32'h0);
    check("rst_vld", 32'(o_rd_vld), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    save(16'h00FF, auth_a);
    settle();
    check("post_rst_data", 32'(o_rd_data), 32'h00FF);
    for (int w = 0; w < 9; w++) rd();

    // Empty reads ignored; done is sticky until clear.
    for (int k = 0; k < 3; k++) rd();
    cyc(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    settle();
    check("done_held", 32'(o_done), 32'h1);
    clr();
    settle();
    check("done_clr", 32'(o_done), 32'h0);

    // Random mix of captures, reads, rare flushes.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 2) == 0), 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0),
          1'($urandom_range(0, 80) == 0));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
